// File: rtl/bayes_readout_seq.sv
// Readout sequencer: reads a burst of consecutive word addresses from all arrays
// and serializes each captured word MSB-first, one bit per lane per cycle.
module bayes_readout_seq #(
  parameter int Narray   = 2,
  parameter int Nword    = 3,
  parameter int Naddr    = 6,
  parameter int READ_LAT = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [Naddr-1:0]       start_addr,
  input  logic [Naddr-1:0]       n_words,
  input  logic                   abort,
  input  logic [2**Nword-1:0]    data_in [2**Narray],
  output logic                   arr_read_en,
  output logic [Naddr-1:0]       arr_addr,
  output logic [2**Narray-1:0]   bit_out,
  output logic                   bit_valid,
  output logic [Nword-1:0]       bit_idx,
  output logic                   word_last,
  output logic                   busy,
  output logic                   done
);

  localparam int NLANE = 2**Narray;
  localparam int WBITS = 2**Nword;
  localparam logic [3:0] WAIT_INIT = 4'(READ_LAT - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_SHIFT = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [Naddr-1:0] addr_q, addr_d;
  logic [Naddr-1:0] rem_q, rem_d;
  logic [3:0]       wait_q, wait_d;
  logic [Nword-1:0] bit_q, bit_d;
  logic [WBITS-1:0] shadow_q [NLANE];
  logic [WBITS-1:0] shadow_d [NLANE];

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    rem_d    = rem_q;
    wait_d   = wait_q;
    bit_d    = bit_q;
    shadow_d = shadow_q;
    // abort wins over every other transition so address/counters freeze
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && !abort) begin
            state_d = S_READ;
            addr_d  = start_addr;
            rem_d   = n_words;
          end
        end
        S_READ: begin
          state_d = S_WAIT;
          wait_d  = WAIT_INIT;
        end
        S_WAIT: begin
          if (wait_q == '0) begin
            shadow_d = data_in;
            bit_d    = '1;
            state_d  = S_SHIFT;
          end else begin
            wait_d = wait_q - 4'd1;
          end
        end
        S_SHIFT: begin
          if (bit_q == '0) begin
            if (rem_q == '0) begin
              state_d = S_DONE;
            end else begin
              rem_d   = rem_q - 1'b1;
              addr_d  = addr_q + 1'b1;
              state_d = S_READ;
            end
          end else begin
            bit_d = bit_q - 1'b1;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      wait_q  <= '0;
      bit_q   <= '0;
      for (int unsigned i = 0; i < NLANE; i++) shadow_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      rem_q    <= rem_d;
      wait_q   <= wait_d;
      bit_q    <= bit_d;
      shadow_q <= shadow_d;
    end
  end

  always_comb begin
    arr_read_en = (state_q == S_READ);
    arr_addr    = addr_q;
    bit_valid   = (state_q == S_SHIFT);
    bit_idx     = bit_valid ? bit_q : '0;
    word_last   = bit_valid && (bit_q == '0) && (rem_q == '0);
    busy        = (state_q != S_IDLE);
    done        = (state_q == S_DONE);
    bit_out     = '0;
    for (int unsigned i = 0; i < NLANE; i++) bit_out[i] = bit_valid & shadow_q[i][bit_q];
  end

endmodule

// File: tb/tb_bayes_readout_seq.sv
// Bench for bayes_readout_seq: READ_LAT=2 and READ_LAT=4 instances share stimulus and
// are checked every cycle against a burst-offset model plus directed literal checks.
module tb_bayes_readout_seq;

  localparam int W = 8;
  localparam int LATS [2] = '{2, 4};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic [5:0] start_addr = '0;
  logic [5:0] n_words = '0;
  logic [7:0] din [4];

  logic [1:0]       re, bv, wl, by, dn;
  logic [1:0][5:0]  ad;
  logic [1:0][3:0]  bo;
  logic [1:0][2:0]  bi;

  int ncmp = 0;
  int nerr = 0;
  bit run_chk = 1'b0;

  always #5 clk = ~clk;

  bayes_readout_seq #(.Narray(2), .Nword(3), .Naddr(6), .READ_LAT(2)) u_lat2 (
    .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr), .n_words(n_words),
    .abort(abort), .data_in(din), .arr_read_en(re[0]), .arr_addr(ad[0]), .bit_out(bo[0]),
    .bit_valid(bv[0]), .bit_idx(bi[0]), .word_last(wl[0]), .busy(by[0]), .done(dn[0]));

  bayes_readout_seq #(.Narray(2), .Nword(3), .Naddr(6), .READ_LAT(4)) u_lat4 (
    .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr), .n_words(n_words),
    .abort(abort), .data_in(din), .arr_read_en(re[1]), .arr_addr(ad[1]), .bit_out(bo[1]),
    .bit_valid(bv[1]), .bit_idx(bi[1]), .word_last(wl[1]), .busy(by[1]), .done(dn[1]));

  task automatic chk(input string name, input int k, input logic [31:0] a, input logic [31:0] e);
    ncmp++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s lat%0d t=%0t got %0h expected %0h", name, LATS[k], $time, a, e);
    end
  endtask

  // Model: a burst is a cycle offset t from its READ cycle; word = t/P, phase = t%P.
  bit         act [2];
  int         t [2], a0 [2], nw [2], lastaddr [2];
  logic [7:0] cap [2][4];

  initial begin
    for (int k = 0; k < 2; k++) begin
      act[k] = 0; t[k] = 0; a0[k] = 0; nw[k] = 0; lastaddr[k] = 0;
      for (int l = 0; l < 4; l++) cap[k][l] = '0;
    end
    forever begin
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
        int p, len, w;
        p   = 1 + LATS[k] + W;
        len = (nw[k] + 1) * p;
        if (!rst_n) begin
          act[k] = 0; lastaddr[k] = 0;
        end else if (act[k]) begin
          if (abort) act[k] = 0;
          else begin
            if (t[k] < len && (t[k] % p) == LATS[k])
              for (int l = 0; l < 4; l++) cap[k][l] = din[l];
            t[k]++;
            if (t[k] > len) act[k] = 0;
          end
        end else if (start && !abort) begin
          act[k] = 1; t[k] = 0; a0[k] = int'(start_addr); nw[k] = int'(n_words);
        end
        if (act[k]) begin
          w = t[k] / p;
          if (w > nw[k]) w = nw[k];
          lastaddr[k] = (a0[k] + w) % 64;
        end
      end
    end
  end

  logic       e_re, e_bv, e_wl, e_by, e_dn;
  logic [3:0] e_bo;
  logic [2:0] e_bi;
  int         e_ad, m_p, m_len, m_ph, m_idx;

  initial forever begin
    @(negedge clk);
    if (rst_n && run_chk) begin
      for (int k = 0; k < 2; k++) begin
        e_re = 0; e_bv = 0; e_wl = 0; e_by = 0; e_dn = 0; e_bo = '0; e_bi = '0;
        e_ad = lastaddr[k];
        if (act[k]) begin
          m_p   = 1 + LATS[k] + W;
          m_len = (nw[k] + 1) * m_p;
          e_by  = 1;
          if (t[k] == m_len) e_dn = 1;
          else begin
            m_ph = t[k] % m_p;
            if (m_ph == 0) e_re = 1;
            if (m_ph > LATS[k]) begin
              m_idx = W - 1 - (m_ph - LATS[k] - 1);
              e_bv  = 1;
              e_bi  = 3'(m_idx);
              for (int l = 0; l < 4; l++) e_bo[l] = cap[k][l][m_idx];
              e_wl  = (m_idx == 0) && (t[k] / m_p == nw[k]);
            end
          end
        end
        chk("arr_read_en", k, 32'(re[k]), 32'(e_re));
        chk("arr_addr",    k, 32'(ad[k]), 32'(e_ad));
        chk("bit_out",     k, 32'(bo[k]), 32'(e_bo));
        chk("bit_valid",   k, 32'(bv[k]), 32'(e_bv));
        chk("bit_idx",     k, 32'(bi[k]), 32'(e_bi));
        chk("word_last",   k, 32'(wl[k]), 32'(e_wl));
        chk("busy",        k, 32'(by[k]), 32'(e_by));
        chk("done",        k, 32'(dn[k]), 32'(e_dn));
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    for (int l = 0; l < 4; l++) din[l] = 8'($urandom);
  endtask

  task automatic chk_all_zero(input string name);
    for (int k = 0; k < 2; k++) begin
      chk({name, "_re"},   k, 32'(re[k]), 32'd0);
      chk({name, "_addr"}, k, 32'(ad[k]), 32'd0);
      chk({name, "_bo"},   k, 32'(bo[k]), 32'd0);
      chk({name, "_bv"},   k, 32'(bv[k]), 32'd0);
      chk({name, "_bi"},   k, 32'(bi[k]), 32'd0);
      chk({name, "_wl"},   k, 32'(wl[k]), 32'd0);
      chk({name, "_busy"}, k, 32'(by[k]), 32'd0);
      chk({name, "_done"}, k, 32'(dn[k]), 32'd0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1);
  end

  logic [7:0] l0, l1;
  int nre, ndn, nwl;

  initial begin
    for (int l = 0; l < 4; l++) din[l] = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk_all_zero("reset");
    run_chk = 1'b1;

    // single word, literal expectations
    l0 = 8'b1010_0101;
    l1 = 8'b0011_1100;
    tick(); start = 1; start_addr = 6'd5; n_words = 6'd0;
    for (int c = 1; c <= 16; c++) begin
      tick(); start = 0;
      if (c == 3) begin din[0] = 8'hA5; din[1] = 8'h3C; din[2] = 8'hFF; din[3] = 8'h00; end
      if (c == 5) begin din[0] = 8'h5A; din[1] = 8'hC3; din[2] = 8'h0F; din[3] = 8'hF0; end
      if (c == 1) begin
        chk("lit_read_en", 0, 32'(re[0]), 32'd1);
        chk("lit_addr", 0, 32'(ad[0]), 32'd5);
      end
      if (c >= 4 && c <= 11) begin
        chk("lit_bit_idx", 0, 32'(bi[0]), 32'(11 - c));
        chk("lit_bit_out", 0, 32'(bo[0]), 32'({1'b0, 1'b1, l1[11 - c], l0[11 - c]}));
      end
      if (c == 11) chk("lit_word_last", 0, 32'(wl[0]), 32'd1);
      if (c == 12) chk("lit_done", 0, 32'(dn[0]), 32'd1);
      if (c == 13) chk("lit_busy_low", 0, 32'(by[0]), 32'd0);
      if (c == 5) chk("lit4_no_valid", 1, 32'(bv[1]), 32'd0);
      if (c == 6) begin
        chk("lit4_valid", 1, 32'(bv[1]), 32'd1);
        chk("lit4_bit_out", 1, 32'(bo[1]), 32'b1010);
      end
    end

    // 3-word burst across the address wrap
    tick(); start = 1; start_addr = 6'd62; n_words = 6'd2;
    ndn = 0; nwl = 0;
    for (int c = 1; c <= 42; c++) begin
      tick(); start = 0;
      if (c == 1)  chk("wrap_addr0", 0, 32'({re[0], ad[0]}), 32'({1'b1, 6'd62}));
      if (c == 12) chk("wrap_addr1", 0, 32'({re[0], ad[0]}), 32'({1'b1, 6'd63}));
      if (c == 23) chk("wrap_addr2", 0, 32'({re[0], ad[0]}), 32'({1'b1, 6'd0}));
      if (c == 34) chk("wrap_done", 0, 32'(dn[0]), 32'd1);
      ndn += int'(dn[0]);
      nwl += int'(wl[0]);
    end
    chk("wrap_done_count", 0, 32'(ndn), 32'd1);
    chk("wrap_last_count", 0, 32'(nwl), 32'd1);

    // abort in cycle 6, restart in cycle 8
    tick(); start = 1; start_addr = 6'd10; n_words = 6'd1;
    for (int c = 1; c <= 24; c++) begin
      tick(); start = 0; abort = 0;
      if (c == 6) abort = 1;
      if (c == 7) begin
        chk("abort_busy", 0, 32'(by[0]), 32'd0);
        chk("abort_valid", 0, 32'(bv[0]), 32'd0);
        chk("abort_busy", 1, 32'(by[1]), 32'd0);
      end
      if (c == 8) begin start = 1; start_addr = 6'd20; n_words = 6'd0; end
      if (c == 9) chk("restart_addr", 0, 32'({re[0], ad[0]}), 32'({1'b1, 6'd20}));
      if (c == 20) chk("restart_done", 0, 32'(dn[0]), 32'd1);
    end

    // start pulses during a burst are ignored
    tick(); start = 1; start_addr = 6'd30; n_words = 6'd1;
    nre = 0; ndn = 0;
    for (int c = 1; c <= 30; c++) begin
      tick();
      start = (c == 3 || c == 10);
      nre += int'(re[0]);
      ndn += int'(dn[0]);
    end
    start = 0;
    chk("ignore_reads", 0, 32'(nre), 32'd2);
    chk("ignore_done", 0, 32'(ndn), 32'd1);

    // asynchronous reset mid-SHIFT
    tick(); start = 1; start_addr = 6'd7; n_words = 6'd3;
    for (int c = 1; c <= 6; c++) begin tick(); start = 0; end
    chk("pre_reset_valid", 0, 32'(bv[0]), 32'd1);
    @(posedge clk); #2;
    rst_n = 0;
    #1;
    chk_all_zero("async_reset");
    tick(); tick();
    rst_n = 1;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("post_reset_idle", 0, 32'(by[0]), 32'd0);
    end

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      tick();
      start      = ($urandom % 6) == 0;
      start_addr = 6'($urandom);
      n_words    = (($urandom % 16) == 0) ? 6'd63 : 6'($urandom % 4);
      abort      = ($urandom % 50) == 0;
    end
    start = 0; abort = 0;
    repeat (20) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
